wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback-data formatter for the 5-stage MIPS datapath.
- Captures MEM-stage results on each clock and extracts and extends load data.
- Drives WB_RegWrite, WB_rd and WB_writedata straight into the register file's WB_RegWrite, rd and writedata inputs.
- Also keeps a retired-instruction counter and a sticky misaligned-load flag.

---
 rtl/wb_stage.sv | 145 ++++++++++++++
 tb/tb_wb_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load-data extraction and extension, a retired-instruction
// counter and a sticky misaligned-load flag.
module wb_stage #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             MEM_Valid,
    input  logic             MEM_RegWrite,
    input  logic             MEM_MemtoReg,
    input  logic [2:0]       MEM_LoadType,
    input  logic [4:0]       MEM_rd,
    input  logic [31:0]      MEM_ALUResult,
    input  logic [31:0]      MEM_ReadData,
    output logic             WB_Valid,
    output logic             WB_RegWrite,
    output logic [4:0]       WB_rd,
    output logic [31:0]      WB_writedata,
    output logic             align_err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        LdW  = 3'b000,
        LdH  = 3'b001,
        LdHu = 3'b010,
        LdB  = 3'b011,
        LdBu = 3'b100
    } load_e;

    // Unlisted load codes behave as LW, so they take the word alignment rule.
    function automatic logic is_misaligned(input logic [2:0] load_type, input logic [1:0] addr);
        logic mis;
        case (load_e'(load_type))
            LdH, LdHu: mis = addr[0];
            LdB, LdBu: mis = 1'b0;
            default:   mis = (addr != 2'b00);
        endcase
        return mis;
    endfunction

    logic             valid_q,     valid_d;
    logic             regwrite_q,  regwrite_d;
    logic             memtoreg_q,  memtoreg_d;
    logic [2:0]       loadtype_q,  loadtype_d;
    logic [4:0]       rd_q,        rd_d;
    logic [31:0]      aluresult_q, aluresult_d;
    logic [31:0]      readdata_q,  readdata_d;
    logic             align_err_q, align_err_d;
    logic [CNT_W-1:0] retired_q,   retired_d;

    logic mem_misaligned;
    logic wb_misaligned;

    assign mem_misaligned = MEM_Valid & MEM_MemtoReg
                          & is_misaligned(MEM_LoadType, MEM_ALUResult[1:0]);
    assign wb_misaligned  = memtoreg_q & is_misaligned(loadtype_q, aluresult_q[1:0]);

    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        memtoreg_d  = memtoreg_q;
        loadtype_d  = loadtype_q;
        rd_d        = rd_q;
        aluresult_d = aluresult_q;
        readdata_d  = readdata_q;
        align_err_d = align_err_q;
        retired_d   = retired_q;
        if (flush) begin
            // Payload fields are held; only the valid bits are killed.
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
        end else if (!stall) begin
            valid_d     = MEM_Valid;
            regwrite_d  = MEM_RegWrite;
            memtoreg_d  = MEM_MemtoReg;
            loadtype_d  = MEM_LoadType;
            rd_d        = MEM_rd;
            aluresult_d = MEM_ALUResult;
            readdata_d  = MEM_ReadData;
            align_err_d = align_err_q | mem_misaligned;
            if (MEM_Valid) begin
                retired_d = retired_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            loadtype_q  <= 3'b000;
            rd_q        <= 5'd0;
            aluresult_q <= 32'd0;
            readdata_q  <= 32'd0;
            align_err_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            loadtype_q  <= loadtype_d;
            rd_q        <= rd_d;
            aluresult_q <= aluresult_d;
            readdata_q  <= readdata_d;
            align_err_q <= align_err_d;
            retired_q   <= retired_d;
        end
    end

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    always_comb begin
        byte_sel = 8'd0;
        unique case (aluresult_q[1:0])
            2'b00: byte_sel = readdata_q[7:0];
            2'b01: byte_sel = readdata_q[15:8];
            2'b10: byte_sel = readdata_q[23:16];
            2'b11: byte_sel = readdata_q[31:24];
        endcase
        half_sel = aluresult_q[1] ? readdata_q[31:16] : readdata_q[15:0];

        case (load_e'(loadtype_q))
            LdB:     load_data = {{24{byte_sel[7]}}, byte_sel};
            LdBu:    load_data = {24'd0, byte_sel};
            LdH:     load_data = {{16{half_sel[15]}}, half_sel};
            LdHu:    load_data = {16'd0, half_sel};
            default: load_data = readdata_q;
        endcase
    end

    assign WB_writedata = memtoreg_q ? load_data : aluresult_q;
    // Suppressing $0 writes keeps forwarding comparators from matching register zero.
    assign WB_RegWrite  = valid_q & regwrite_q & (rd_q != 5'd0) & ~wb_misaligned;
    assign WB_Valid     = valid_q;
    assign WB_rd        = rd_q;
    assign align_err    = align_err_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage (CNT_W=4 build) against a behavioural model.
module tb_wb_stage;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             MEM_Valid = 1'b0;
    logic             MEM_RegWrite = 1'b0;
    logic             MEM_MemtoReg = 1'b0;
    logic [2:0]       MEM_LoadType = 3'd0;
    logic [4:0]       MEM_rd = 5'd0;
    logic [31:0]      MEM_ALUResult = 32'd0;
    logic [31:0]      MEM_ReadData = 32'd0;
    logic             WB_Valid;
    logic             WB_RegWrite;
    logic [4:0]       WB_rd;
    logic [31:0]      WB_writedata;
    logic             align_err;
    logic [CNT_W-1:0] retired;

    int n_pass = 0;
    int n_total = 0;

    // Model of the instruction currently in WB.
    bit          m_valid, m_rw, m_m2r, m_err;
    bit [2:0]    m_lt;
    bit [4:0]    m_rd;
    bit [31:0]   m_alu, m_rdata;
    int unsigned m_ret;

    wb_stage #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .MEM_Valid    (MEM_Valid),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_MemtoReg (MEM_MemtoReg),
        .MEM_LoadType (MEM_LoadType),
        .MEM_rd       (MEM_rd),
        .MEM_ALUResult(MEM_ALUResult),
        .MEM_ReadData (MEM_ReadData),
        .WB_Valid     (WB_Valid),
        .WB_RegWrite  (WB_RegWrite),
        .WB_rd        (WB_rd),
        .WB_writedata (WB_writedata),
        .align_err    (align_err),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    function automatic bit model_misal(input bit [2:0] lt, input bit [31:0] addr);
        if (lt == 3'd3 || lt == 3'd4) return 1'b0;
        if (lt == 3'd1 || lt == 3'd2) return (addr % 2) != 0;
        return (addr % 4) != 0;
    endfunction

    function automatic bit [31:0] model_data();
        bit [7:0]  b;
        bit [15:0] h;
        int        sx;
        if (!m_m2r) return m_alu;
        b = 8'(m_rdata >> (8 * (m_alu % 4)));
        h = 16'(m_rdata >> (16 * ((m_alu / 2) % 2)));
        case (m_lt)
            3'd3: begin sx = $signed(b); return sx; end
            3'd4: return {24'd0, b};
            3'd1: begin sx = $signed(h); return sx; end
            3'd2: return {16'd0, h};
            default: return m_rdata;
        endcase
    endfunction

    function automatic bit model_we();
        return m_valid && m_rw && (m_rd != 0) && !(m_m2r && model_misal(m_lt, m_alu));
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_m2r = 0; m_err = 0; m_lt = 0; m_rd = 0;
        m_alu = 0; m_rdata = 0; m_ret = 0;
    endtask

    // Present one MEM-stage slot across a posedge; returns at the following negedge.
    task automatic drive(input bit v, input bit rw, input bit m2r, input bit [2:0] lt,
                         input bit [4:0] rd, input bit [31:0] alu, input bit [31:0] rdat,
                         input bit st, input bit fl);
        MEM_Valid = v; MEM_RegWrite = rw; MEM_MemtoReg = m2r; MEM_LoadType = lt;
        MEM_rd = rd; MEM_ALUResult = alu; MEM_ReadData = rdat; stall = st; flush = fl;
        @(posedge clk);
        if (fl) begin
            m_valid = 0; m_rw = 0;
        end else if (!st) begin
            m_valid = v; m_rw = rw; m_m2r = m2r; m_lt = lt; m_rd = rd;
            m_alu = alu; m_rdata = rdat;
            if (v && m2r && model_misal(lt, alu)) m_err = 1;
            if (v) m_ret = (m_ret + 1) % (1 << CNT_W);
        end
        @(negedge clk);
        stall = 0; flush = 0; MEM_Valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        model_reset();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_total++;
        if ({WB_Valid, WB_RegWrite, WB_rd, WB_writedata, align_err, retired} !== '0)
            $display("FAIL reset_idle: got v=%b we=%b rd=%0d wd=%h err=%b ret=%0d, want all 0",
                     WB_Valid, WB_RegWrite, WB_rd, WB_writedata, align_err, retired);
        else n_pass++;
    endtask

    task automatic test_alu();
        do_reset();
        drive(1, 1, 0, 0, 5, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0);
        n_total++;
        if (WB_RegWrite !== 1'b1 || WB_rd !== 5'd5 || WB_writedata !== 32'h1234_5678
            || retired !== 4'd1)
            $display("FAIL alu_op: got we=%b rd=%0d wd=%h ret=%0d, want 1 5 12345678 1",
                     WB_RegWrite, WB_rd, WB_writedata, retired);
        else n_pass++;
    endtask

    task automatic test_loads();
        bit [2:0]  lt  [5] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0};
        bit [31:0] adr [5] = '{32'h100A, 32'h100B, 32'h100E, 32'h1000, 32'h2000};
        bit [31:0] exp [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                               32'h80FF_7F01};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, lt[i], 5'(i + 1), adr[i], 32'h80FF_7F01, 0, 0);
            n_total++;
            if (WB_writedata !== exp[i] || WB_RegWrite !== 1'b1)
                $display("FAIL load_%0d: got wd=%h we=%b, want wd=%h we=1",
                         i, WB_writedata, WB_RegWrite, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_misaligned();
        int unsigned r0;
        do_reset();
        drive(1, 1, 0, 0, 3, 32'h5, 0, 0, 0);
        r0 = retired;
        drive(1, 1, 1, 3'd0, 8, 32'h1001, 32'h1111_2222, 0, 0);
        n_total++;
        if (WB_RegWrite !== 1'b0 || align_err !== 1'b1 || retired !== 4'(r0 + 1))
            $display("FAIL misaligned_lw: got we=%b err=%b ret=%0d, want 0 1 %0d",
                     WB_RegWrite, align_err, retired, r0 + 1);
        else n_pass++;
        drive(1, 1, 0, 0, 4, 32'h77, 0, 0, 0);
        drive(1, 1, 1, 3'd4, 6, 32'h1003, 32'h8000_0000, 0, 0);
        n_total++;
        if (align_err !== 1'b1 || WB_RegWrite !== 1'b1 || WB_writedata !== 32'h80)
            $display("FAIL sticky_err: got err=%b we=%b wd=%h, want 1 1 00000080",
                     align_err, WB_RegWrite, WB_writedata);
        else n_pass++;
    endtask

    task automatic test_stall_flush();
        int unsigned r0;
        do_reset();
        drive(1, 1, 0, 0, 9, 32'hCAFE_0009, 0, 0, 0);
        r0 = retired;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 5'(20 + i), $urandom, $urandom, 1, 0);
            n_total++;
            if (WB_Valid !== 1'b1 || WB_RegWrite !== 1'b1 || WB_rd !== 5'd9
                || WB_writedata !== 32'hCAFE_0009 || retired !== 4'(r0))
                $display("FAIL stall_%0d: got v=%b we=%b rd=%0d wd=%h ret=%0d, want 1 1 9 cafe0009 %0d",
                         i, WB_Valid, WB_RegWrite, WB_rd, WB_writedata, retired, r0);
            else n_pass++;
        end
        drive(1, 1, 0, 0, 11, 32'h1, 0, 1, 1);
        n_total++;
        if (WB_Valid !== 1'b0 || WB_RegWrite !== 1'b0 || retired !== 4'(r0))
            $display("FAIL flush_stall: got v=%b we=%b ret=%0d, want 0 0 %0d",
                     WB_Valid, WB_RegWrite, retired, r0);
        else n_pass++;
    endtask

    task automatic test_rd_zero();
        do_reset();
        drive(1, 1, 0, 0, 0, 32'h55, 0, 0, 0);
        n_total++;
        if (WB_RegWrite !== 1'b0 || WB_Valid !== 1'b1)
            $display("FAIL rd_zero: got we=%b v=%b, want 0 1", WB_RegWrite, WB_Valid);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) drive(1, 1, 0, 0, 1, 32'(i), 0, 0, 0);
        n_total++;
        if (retired !== 4'd15) $display("FAIL wrap_pre: got ret=%0d, want 15", retired);
        else n_pass++;
        drive(1, 1, 0, 0, 1, 32'h99, 0, 0, 0);
        n_total++;
        if (retired !== 4'd0) $display("FAIL wrap: got ret=%0d, want 0", retired);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 1, 1, 3'd0, 8, 32'h3, 32'h1, 0, 0);
        drive(1, 1, 0, 0, 12, 32'hABCD, 0, 0, 0);
        MEM_Valid = 1; stall = 1;
        #2;
        rst = 0;
        #1;
        n_total++;
        if ({WB_Valid, WB_RegWrite, WB_rd, WB_writedata, align_err, retired} !== '0)
            $display("FAIL async_reset: got v=%b we=%b rd=%0d wd=%h err=%b ret=%0d, want all 0",
                     WB_Valid, WB_RegWrite, WB_rd, WB_writedata, align_err, retired);
        else n_pass++;
        model_reset();
        @(negedge clk);
        stall = 0; MEM_Valid = 0;
        rst = 1;
    endtask

    task automatic test_random();
        bit [31:0] exp_wd;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(bit'($urandom_range(0, 3) != 0), bit'($urandom), bit'($urandom),
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                  $urandom, $urandom, bit'($urandom_range(0, 4) == 0),
                  bit'($urandom_range(0, 7) == 0));
            exp_wd = model_data();
            n_total++;
            if (WB_Valid !== m_valid || WB_RegWrite !== model_we() || WB_rd !== m_rd
                || align_err !== m_err || retired !== 4'(m_ret)
                || (m_valid && WB_writedata !== exp_wd))
                $display("FAIL random_%0d: got v=%b we=%b rd=%0d wd=%h err=%b ret=%0d, want v=%b we=%b rd=%0d wd=%h err=%b ret=%0d",
                         i, WB_Valid, WB_RegWrite, WB_rd, WB_writedata, align_err, retired,
                         m_valid, model_we(), m_rd, exp_wd, m_err, m_ret);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu();
        test_loads();
        test_misaligned();
        test_stall_flush();
        test_rd_zero();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
